// File: rtl/hilo_muldiv_ctrl.sv
//------------------------------------------------------------------------------
// hilo_muldiv_ctrl
//
// Multi-cycle multiply/divide sequencer that owns the architectural HI/LO pair.
// Multiplies (MULT/MULTU/MADD*/MSUB*) wait a fixed MUL_LATENCY cycles and then
// commit the 64-bit result. Divides run a 32-step restoring divider followed by
// a sign fix-up/commit edge. MTHI/MTLO write HI/LO directly from IDLE.
//
// Ports:
//   clk        in   1   clock, rising edge
//   resetn     in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_op     in   4   0 MULT 1 MULTU 2 DIV 3 DIVU 4 MADD 5 MADDU 6 MSUB
//                       7 MSUBU 8 MTHI 9 MTLO 10..15 no-op
//   req_a      in  32   rs operand (dividend / multiplicand / MTHI,MTLO source)
//   req_b      in  32   rt operand (divisor / multiplier)
//   req_ready  out  1   high only in IDLE
//   flush      in   1   aborts any in-flight op and drops a presented request
//   busy       out  1   state != IDLE
//   done       out  1   one-cycle pulse after a mul/div commit
//   hi         out 32   architectural HI
//   lo         out 32   architectural LO
//
// State table:
//   S_IDLE | ready for a request; MTHI/MTLO handled here
//   S_MUL  | counting down MUL_LATENCY; commit when counter reads 1
//   S_DIV  | 32 restoring steps, then fix-up/commit when counter reads 0
//------------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
    parameter int MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    state_t      r_state;
    state_t      w_next_state;

    logic [5:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dbz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_accept;
    logic        w_req_is_mul;
    logic        w_req_is_div;
    logic        w_mul_last;
    logic        w_div_last;
    logic        w_mul_commit;
    logic        w_div_commit;

    logic        w_mul_signed;
    logic [63:0] w_mul_a64;
    logic [63:0] w_mul_b64;
    logic [63:0] w_prod;
    logic [63:0] w_acc;
    logic [63:0] w_mul_res;

    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    logic        w_div_signed;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;

    //--------------------------------------------------------------------------
    // Request decode
    //--------------------------------------------------------------------------
    assign w_accept = req_valid && (r_state == S_IDLE) && !flush;

    always_comb begin
        w_req_is_mul = 1'b0;
        w_req_is_div = 1'b0;
        case (req_op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:
                w_req_is_mul = 1'b1;
            OP_DIV, OP_DIVU:
                w_req_is_div = 1'b1;
            default: ;
        endcase
    end

    // Signed divide works on magnitudes; signs are reapplied at commit.
    assign w_div_signed = (req_op == OP_DIV);
    assign w_a_abs      = (w_div_signed && req_a[31]) ? (32'd0 - req_a) : req_a;
    assign w_b_abs      = (w_div_signed && req_b[31]) ? (32'd0 - req_b) : req_b;

    //--------------------------------------------------------------------------
    // Commit conditions (flush suppresses any commit on the same edge)
    //--------------------------------------------------------------------------
    assign w_mul_last   = (r_state == S_MUL) && (r_cnt == 6'd1);
    assign w_div_last   = (r_state == S_DIV) && (r_dbz || (r_cnt == 6'd0));
    assign w_mul_commit = w_mul_last && !flush;
    assign w_div_commit = w_div_last && !flush;

    //--------------------------------------------------------------------------
    // Multiply datapath: even ops are signed. Sign/zero extending to 64 bits
    // and keeping the low 64 bits of the product gives the right result for
    // both flavours.
    //--------------------------------------------------------------------------
    assign w_mul_signed = !r_op[0];
    assign w_mul_a64    = w_mul_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_mul_b64    = w_mul_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod       = w_mul_a64 * w_mul_b64;
    assign w_acc        = {r_hi, r_lo};

    always_comb begin
        w_mul_res = w_prod;
        case (r_op)
            OP_MADD, OP_MADDU: w_mul_res = w_acc + w_prod;
            OP_MSUB, OP_MSUBU: w_mul_res = w_acc - w_prod;
            default:           w_mul_res = w_prod;
        endcase
    end

    //--------------------------------------------------------------------------
    // Restoring divide step. r_quo starts as the dividend and its MSBs shift
    // into the partial remainder while quotient bits shift in at the bottom.
    // The partial remainder is always below the divisor, so 33 bits suffice
    // for the trial subtraction.
    //--------------------------------------------------------------------------
    assign w_div_shift = {r_rem, r_quo[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_quo_fix   = r_neg_q ? (32'd0 - r_quo) : r_quo;
    assign w_rem_fix   = r_neg_r ? (32'd0 - r_rem) : r_rem;

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_req_is_mul) begin
                        w_next_state = S_MUL;
                    end else if (w_accept && w_req_is_div) begin
                        w_next_state = S_DIV;
                    end
                end
                S_MUL: begin
                    if (w_mul_last) begin
                        w_next_state = S_IDLE;
                    end
                end
                S_DIV: begin
                    if (w_div_last) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Operand, counter and divider registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= 6'd0;
            r_op    <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            if (w_accept && w_req_is_mul) begin
                r_op  <= req_op;
                r_a   <= req_a;
                r_b   <= req_b;
                r_cnt <= 6'(MUL_LATENCY);
            end else if (w_accept && w_req_is_div) begin
                r_op    <= req_op;
                r_b     <= w_b_abs;
                r_quo   <= w_a_abs;
                r_rem   <= 32'd0;
                r_neg_q <= w_div_signed && (req_a[31] ^ req_b[31]);
                r_neg_r <= w_div_signed && req_a[31];
                r_dbz   <= (req_b == 32'd0);
                r_cnt   <= 6'd32;
            end else if (r_state == S_MUL) begin
                r_cnt <= r_cnt - 6'd1;
            end else if ((r_state == S_DIV) && !r_dbz && (r_cnt != 6'd0)) begin
                r_cnt <= r_cnt - 6'd1;
                if (!w_div_diff[32]) begin
                    r_rem <= w_div_diff[31:0];
                    r_quo <= {r_quo[30:0], 1'b1};
                end else begin
                    r_rem <= w_div_shift[31:0];
                    r_quo <= {r_quo[30:0], 1'b0};
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Architectural HI/LO and done pulse
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_mul_commit || w_div_commit;
            if (w_accept && (req_op == OP_MTHI)) begin
                r_hi <= req_a;
            end
            if (w_accept && (req_op == OP_MTLO)) begin
                r_lo <= req_a;
            end
            if (w_mul_commit) begin
                r_hi <= w_mul_res[63:32];
                r_lo <= w_mul_res[31:0];
            end
            // Divide by zero leaves HI/LO untouched but still reports done.
            if (w_div_commit && !r_dbz) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign req_ready = (r_state == S_IDLE);
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    hilo_muldiv_ctrl #(.MUL_LATENCY(L)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        logic [3:0]  op;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: plain 64-bit arithmetic on the current HI/LO.
    task automatic model_issue(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int c);
        logic [63:0] acc, p, qv, rv;
        longint      sa, sb;
        exp_t        e;
        acc = {m_hi, m_lo};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        e.op = op;
        case (op)
            4'd0, 4'd4, 4'd6: p = 64'(sa * sb);
            default:          p = {32'd0, a} * {32'd0, b};
        endcase
        case (op)
            4'd0, 4'd1: begin acc = p;       e.cyc = c + 1 + L; end
            4'd4, 4'd5: begin acc = acc + p; e.cyc = c + 1 + L; end
            4'd6, 4'd7: begin acc = acc - p; e.cyc = c + 1 + L; end
            4'd2, 4'd3: begin
                if (b == 32'd0) begin
                    e.cyc = c + 2;
                end else begin
                    if (op == 4'd2) begin
                        qv = 64'(sa / sb);
                        rv = 64'(sa % sb);
                    end else begin
                        qv = {32'd0, a / b};
                        rv = {32'd0, a % b};
                    end
                    acc = {rv[31:0], qv[31:0]};
                    e.cyc = c + 34;
                end
            end
            4'd8: acc[63:32] = a;
            4'd9: acc[31:0]  = a;
            default: ;
        endcase
        m_hi = acc[63:32];
        m_lo = acc[31:0];
        e.hi = m_hi;
        e.lo = m_lo;
        if (op <= 4'd7) q.push_back(e);
    endtask

    // Called and returns at a negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit track);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        if (track) model_issue(op, a, b, cyc);
        @(negedge clk);
        req_valid = 1'b0;
        if (track && op >= 4'd8) begin
            chk("direct_hi", 64'(hi), 64'(m_hi));
            chk("direct_lo", 64'(lo), 64'(m_lo));
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            chk("ready_vs_busy", 64'(req_ready), 64'(!busy));
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("op%0d_hi", e.op), 64'(hi), 64'(e.hi));
                    chk($sformatf("op%0d_lo", e.op), 64'(lo), 64'(e.lo));
                    chk($sformatf("op%0d_done_cycle", e.op), 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int n;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        #12;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(4'd0, 32'hFFFFFFFF, 32'd2, 1);
        issue(4'd1, 32'hFFFFFFFF, 32'd2, 1);
        issue(4'd2, 32'hFFFFFFF9, 32'd2, 1);
        issue(4'd3, 32'd7, 32'd2, 1);
        issue(4'd2, 32'h80000000, 32'hFFFFFFFF, 1);
        issue(4'd8, 32'd5, 32'd0, 1);
        issue(4'd9, 32'd6, 32'd0, 1);
        issue(4'd3, 32'd1234, 32'd0, 1);
        issue(4'd8, 32'd0, 32'd0, 1);
        issue(4'd9, 32'd10, 32'd0, 1);
        issue(4'd4, 32'd3, 32'd4, 1);
        issue(4'd6, 32'd5, 32'd5, 1);
        issue(4'd8, 32'd0, 32'd0, 1);
        issue(4'd9, 32'd0, 32'd0, 1);
        issue(4'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        issue(4'd12, 32'h12345678, 32'd9, 1);
        wait_idle();

        // Flush during DIV
        issue(4'd8, 32'h11, 32'd0, 1);
        issue(4'd9, 32'h11, 32'd0, 1);
        issue(4'd2, 32'd1000, 32'd7, 0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_div_hi", 64'(hi), 64'h11);
        chk("flush_div_lo", 64'(lo), 64'h11);
        chk("flush_div_ready", 64'(req_ready), 64'd1);

        // Flush exactly on the MULT commit edge
        issue(4'd0, 32'd7, 32'd9, 0);
        repeat (L - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_commit_hi", 64'(hi), 64'h11);
        chk("flush_commit_lo", 64'(lo), 64'h11);
        chk("flush_commit_ready", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);

        // MTLO presented with flush is dropped
        req_valid = 1'b1; req_op = 4'd9; req_a = 32'hDEAD; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_mtlo_lo", 64'(lo), 64'h11);

        // Busy rejection, then MTLO accepted on the done cycle
        issue(4'd0, 32'd6, 32'd7, 1);
        req_valid = 1'b1; req_op = 4'd9; req_a = 32'hAA;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("busy_reject_done_seen", 64'(done), 64'd1);
        m_lo = 32'hAA;
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_mtlo_lo", 64'(lo), 64'hAA);
        chk("b2b_mtlo_hi", 64'(hi), 64'(m_hi));

        // Randomized stream
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 100));
            issue(rop, ra, rb, 1);
        end
        wait_idle();

        // Async reset in the middle of a divide
        issue(4'd3, 32'd100, 32'd3, 0);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (40) @(negedge clk);
        chk("post_rst_hi", 64'(hi), 64'd0);
        chk("post_rst_queue", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair. Decode routes MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO here; none of them write the GPR file. The block runs a fixed-latency multiply counter and a 32-iteration restoring divider, commits results to HI/LO, and exposes `busy` so the pipeline stalls later HI/LO readers (MFHI/MFLO/MADD*) and refuses new requests until commit.

## Interface
Parameters:
- `MUL_LATENCY`, default 4: cycles spent in MUL state (range 1..15).

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_op`  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO, 10–15 no-op
- `req_a`  in  32  rs value (dividend / multiplicand / MTHI, MTLO source)
- `req_b`  in  32  rt value (divisor / multiplier)
- `req_ready`  out  1  high only in IDLE
- `flush`  in  1  exception/flush; aborts in-flight op
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse after a mul/div commit
- `hi`  out  32  architectural HI
- `lo`  out  32  architectural LO

## Operation
- States: IDLE, MUL, DIV. Handshake: accept on edge where `req_valid && req_ready && !flush`.
- Accepted in IDLE:
  - MTHI/MTLO: write `hi`/`lo` ← `req_a` at the accept edge; stay IDLE; no `done`.
  - Ops 10–15: no effect.
  - ops 0,1,4–7: latch operands and op; load counter with `MUL_LATENCY`; go to MUL.
  - ops 2,3 with `req_b` ≠ 0: latch absolute values (DIV) or raw values (DIVU) and the sign of each; go to DIV with iteration count 32.
  - ops 2,3 with `req_b` = 0: go to DIV flagged divide-by-zero; commit edge is the first DIV edge, and HI/LO stay unchanged (`done` still pulses).
- MUL: counter decrements each edge; on the edge where it is 1, commit. 64-bit product is signed for 0/4/6 and unsigned for 1/5/7. Commit writes {hi,lo} ← P (MULT/MULTU), {hi,lo}+P (MADD*), or {hi,lo}−P (MSUB*), all mod 2^64. HI/LO are sampled at the commit edge.
- DIV: one restoring-division step per edge for 32 edges, then one fix-up/commit edge. DIV signs: quotient negated if operand signs differ; remainder takes the dividend's sign. lo ← quotient, hi ← remainder. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000 and hi=0 (32-bit wrap).
- Commit edge: state → IDLE, `done` ← 1 for exactly one cycle.
- `flush` has priority over everything. At the next edge the state goes to IDLE, there is no commit and no `done`. A request presented with `flush` is dropped, including MTHI/MTLO. A flush on the commit edge suppresses the commit.
- Requests while busy are ignored; `req_ready` = 0.

## Timing
- Reset (async, `resetn`=0): hi=0, lo=0, state IDLE, `busy`=0, `req_ready`=1, `done`=0; counters cleared.
- MTHI/MTLO: new value visible the cycle after the accept edge.
- Mul ops: accept edge E0, commit edge E0+`MUL_LATENCY`. `busy` is high for `MUL_LATENCY` cycles. New HI/LO, `done`=1 and `req_ready`=1 appear together in the cycle after commit.
- Div (b≠0): commit edge E0+33, so `busy` is high for 33 cycles. Div by zero: commit edge E0+1.
- Back-to-back: a new request can be accepted in the same cycle `done` is high.
- `busy`, `req_ready`, `hi`, `lo` and `done` are all driven from registers, with no combinational path from `req_*`. `req_ready` = !`busy`.

## Test plan
- Reset: assert `resetn`=0 mid-DIV → immediately hi=lo=0, `busy`=0, `req_ready`=1. After release, no `done` pulse.
- MULT a=0xFFFFFFFF, b=2 → after 4 edges hi=0xFFFFFFFF, lo=0xFFFFFFFE, `done` high 1 cycle. MULTU same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → 33 edges later lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. DIVU by 0 with hi=5, lo=6 → unchanged, `done` after 1 edge.
- MTHI 0, MTLO 10, then MADD 3,4 → hi=0, lo=22. Then MSUB 5,5 → hi=0xFFFFFFFF, lo=0xFFFFFFFD. MADDU 0xFFFFFFFF,0xFFFFFFFF from hi=lo=0 → hi=0xFFFFFFFE, lo=1.
- Flush: DIV started with hi=lo=0x11, `flush` at cycle 10 → hi/lo remain 0x11, no `done`, `req_ready`=1 next cycle. Flush on the exact commit edge of MULT → no update. MTLO with `flush` → dropped.
- Busy rejection: MULT accepted, then `req_valid` held with MTLO 0xAA during MUL → ignored, lo ends as the product. MTLO accepted on the `done` cycle → lo=0xAA next cycle.
